// File: rtl/coreport_pkg.sv
// Shared register map and interrupt-mode helpers for the coreport_edge GPIO port.
package coreport_pkg;

  localparam int unsigned BUS_ADR_W  = 32;
  localparam int unsigned ADDR_DEC_W = 8;

  localparam logic [ADDR_DEC_W-1:0] ADDR_DATA = 8'h00;
  localparam logic [ADDR_DEC_W-1:0] ADDR_DDR  = 8'h04;
  localparam logic [ADDR_DEC_W-1:0] ADDR_IMR  = 8'h08;
  localparam logic [ADDR_DEC_W-1:0] ADDR_IFR  = 8'h0C;
  localparam logic [ADDR_DEC_W-1:0] ADDR_IER  = 8'h10;
  localparam logic [ADDR_DEC_W-1:0] ADDR_IPR  = 8'h14;
  localparam logic [ADDR_DEC_W-1:0] ADDR_IBE  = 8'h18;
  localparam logic [ADDR_DEC_W-1:0] ADDR_SET  = 8'h1C;
  localparam logic [ADDR_DEC_W-1:0] ADDR_CLR  = 8'h20;
  localparam logic [ADDR_DEC_W-1:0] ADDR_TGL  = 8'h24;
  localparam logic [ADDR_DEC_W-1:0] ADDR_INV  = 8'h28;
  localparam logic [ADDR_DEC_W-1:0] ADDR_OUT  = 8'h2C;
  localparam logic [ADDR_DEC_W-1:0] ADDR_LAST = 8'h2C;

  typedef enum logic [2:0] {
    IMODE_LEVEL_LO,
    IMODE_LEVEL_HI,
    IMODE_EDGE_FALL,
    IMODE_EDGE_RISE,
    IMODE_EDGE_BOTH
  } imode_e;

  // Per-pin mode from the IER/IPR/IBE bits; IBE only matters in edge mode.
  function automatic imode_e pin_mode(input logic ier, input logic ipr, input logic ibe);
    imode_e m;
    if (!ier)     m = ipr ? IMODE_LEVEL_HI : IMODE_LEVEL_LO;
    else if (ibe) m = IMODE_EDGE_BOTH;
    else          m = ipr ? IMODE_EDGE_RISE : IMODE_EDGE_FALL;
    return m;
  endfunction

  function automatic logic mode_event(input imode_e mode, input logic cur, input logic prev);
    logic ev;
    ev = 1'b0;
    case (mode)
      IMODE_LEVEL_LO:  ev = ~cur;
      IMODE_LEVEL_HI:  ev = cur;
      IMODE_EDGE_FALL: ev = ~cur & prev;
      IMODE_EDGE_RISE: ev = cur & ~prev;
      IMODE_EDGE_BOTH: ev = cur ^ prev;
      default:         ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/coreport_edge_if.sv
// Wishbone classic slave bundle for coreport_edge.
interface coreport_edge_if
  import coreport_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();
  logic [BUS_ADR_W-1:0] wb_adr_i;
  logic [WIDTH-1:0]     wb_dat_i;
  logic                 wb_we_i;
  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic [2:0]           wb_cti_i;
  logic [1:0]           wb_bte_i;
  logic [WIDTH-1:0]     wb_dat_o;
  logic                 wb_ack_o;
  logic                 wb_err_o;
  logic                 wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/coreport_sync.sv
// Input synchroniser, previous-value register, priming counter and per-pin
// level/edge event detection.
module coreport_sync
  import coreport_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic [WIDTH-1:0] inv,
  input  logic [WIDTH-1:0] ier,
  input  logic [WIDTH-1:0] ipr,
  input  logic [WIDTH-1:0] ibe,
  output logic [WIDTH-1:0] logical_c,
  output logic [WIDTH-1:0] evt_c,
  output logic             primed_c
);

  localparam int unsigned CNT_MAX = SYNC_STAGES + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev <= '0;
      cnt  <= '0;
    end else begin
      chain[0] <= gpio_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= logical_c;
      if (cnt != CNT_W'(CNT_MAX)) cnt <= cnt + CNT_W'(1);
    end
  end

  assign logical_c = chain[SYNC_STAGES-1] ^ inv;
  // Held off until the chain has filled, so reset-time zeros never look like edges.
  assign primed_c  = (cnt == CNT_W'(CNT_MAX));

  always_comb begin
    evt_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      evt_c[i] = mode_event(pin_mode(ier[i], ipr[i], ibe[i]), logical_c[i], prev[i]);
  end

endmodule

// File: rtl/coreport_edge.sv
// GPIO port on Wishbone classic: register file, bus decode, registered ack/err
// and interrupt flag logic around the coreport_sync input stage.
module coreport_edge
  import coreport_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      SYNC_STAGES   = 2,
  parameter logic [WIDTH-1:0] INITIAL_DATAR = '0,
  parameter logic [WIDTH-1:0] INITIAL_DDR   = '0
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  coreport_edge_if.slave   wb,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] datar, ddr, imr, ifr, ier, ipr, ibe, inv;
  logic [WIDTH-1:0] dat_q;
  logic             ack_q, err_q;

  logic [WIDTH-1:0]      logical_c, evt_c, qevt_c, w1c_c, rdata_c, wdat_c;
  logic                  primed_c, accept_c, valid_c, wr_c;
  logic [ADDR_DEC_W-1:0] adr_c;
  logic                  unused_bus_bits;

  coreport_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .gpio_i    (gpio_i),
    .inv       (inv),
    .ier       (ier),
    .ipr       (ipr),
    .ibe       (ibe),
    .logical_c (logical_c),
    .evt_c     (evt_c),
    .primed_c  (primed_c)
  );

  assign adr_c    = wb.wb_adr_i[ADDR_DEC_W-1:0];
  assign wdat_c   = wb.wb_dat_i;
  assign accept_c = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
  assign valid_c  = (adr_c[1:0] == 2'b00) && (adr_c <= ADDR_LAST);
  assign wr_c     = accept_c & wb.wb_we_i & valid_c;
  assign w1c_c    = (wr_c && adr_c == ADDR_IFR) ? wdat_c : '0;
  assign qevt_c   = evt_c & imr & ~ddr & {WIDTH{primed_c}};

  assign unused_bus_bits = ^{wb.wb_adr_i[BUS_ADR_W-1:ADDR_DEC_W], wb.wb_cti_i, wb.wb_bte_i};

  // Read mux; write-only and unmapped offsets read as zero.
  always_comb begin
    rdata_c = '0;
    case (adr_c)
      ADDR_DATA: rdata_c = logical_c;
      ADDR_DDR:  rdata_c = ddr;
      ADDR_IMR:  rdata_c = imr;
      ADDR_IFR:  rdata_c = ifr;
      ADDR_IER:  rdata_c = ier;
      ADDR_IPR:  rdata_c = ipr;
      ADDR_IBE:  rdata_c = ibe;
      ADDR_INV:  rdata_c = inv;
      ADDR_OUT:  rdata_c = datar;
      default:   rdata_c = '0;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      datar <= INITIAL_DATAR;
      ddr   <= INITIAL_DDR;
      imr   <= '0;
      ifr   <= '0;
      ier   <= '0;
      ipr   <= '0;
      ibe   <= '0;
      inv   <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= accept_c & valid_c;
      err_q <= accept_c & ~valid_c;
      if (accept_c) dat_q <= (valid_c && !wb.wb_we_i) ? rdata_c : '0;
      // New events take priority over a same-cycle write-1-to-clear.
      ifr <= (ifr & ~w1c_c) | qevt_c;
      if (wr_c) begin
        case (adr_c)
          ADDR_DATA: datar <= wdat_c ^ inv;
          ADDR_DDR:  ddr   <= wdat_c;
          ADDR_IMR:  imr   <= wdat_c;
          ADDR_IER:  ier   <= wdat_c;
          ADDR_IPR:  ipr   <= wdat_c;
          ADDR_IBE:  ibe   <= wdat_c;
          ADDR_SET:  datar <= datar | wdat_c;
          ADDR_CLR:  datar <= datar & ~wdat_c;
          ADDR_TGL:  datar <= datar ^ wdat_c;
          ADDR_INV:  inv   <= wdat_c;
          default:   ;
        endcase
      end
    end
  end

  assign wb.wb_dat_o = dat_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_rty_o = 1'b0;
  assign gpio_o      = datar;
  assign gpio_oe     = ddr;
  assign irq         = |ifr;

endmodule
